scarv_soc_mtime: RTL and testbench



---
 rtl/scarv_soc_mtime.sv | 127 ++++++++++++
 tb/tb_scarv_soc_mtime.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scarv_soc_mtime.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, ctrl register, registered timer_irq.
// Define SCARV_SOC_MTIME_WRITE_EN to make mtime words 0/1 writable from the bus.
module scarv_soc_mtime #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        mem_req,
    output logic        mem_gnt,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic        timer_irq
);

`ifdef SCARV_SOC_MTIME_WRITE_EN
    localparam bit MTIME_WR = 1'b1;
`else
    localparam bit MTIME_WR = 1'b0;
`endif

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        ctrl_en;
    logic        ctrl_mask;
    logic [15:0] pre_cnt;

    logic [2:0]  sel;
    logic        accept;
    logic        sel_err;
    logic        wr;
    logic        tick;
    logic [31:0] rd_val;
    logic        addr_unused;

    // Handshake: a request transfers on mem_req && mem_gnt; a response transfers on
    // mem_recv && mem_ack. mem_gnt opens whenever the response slot is empty or draining.
    assign mem_gnt     = !mem_recv || mem_ack;
    assign accept      = mem_req && mem_gnt;
    assign sel         = mem_addr[ADDR_LSB+2:ADDR_LSB];
    assign addr_unused = ^mem_addr;

    assign sel_err = (sel > 3'd4) || (mem_wen && !MTIME_WR && (sel <= 3'd1));
    assign wr      = accept && mem_wen && !sel_err;
    assign tick    = ctrl_en && (pre_cnt == PRE_MAX);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = strb[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        rd_val = 32'd0;
        case (sel)
            3'd0:    rd_val = mtime[31:0];
            3'd1:    rd_val = mtime[63:32];
            3'd2:    rd_val = mtimecmp[31:0];
            3'd3:    rd_val = mtimecmp[63:32];
            3'd4:    rd_val = {30'd0, ctrl_mask, ctrl_en};
            default: rd_val = 32'd0;
        endcase
    end

    // A bus write to either mtime word replaces that cycle's increment for the whole value.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_en   <= 1'b1;
            ctrl_mask <= 1'b0;
            pre_cnt   <= 16'd0;
            timer_irq <= 1'b0;
        end else begin
            if (ctrl_en) begin
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            end
            if (wr && sel == 3'd0) begin
                mtime[31:0] <= merge(mtime[31:0], mem_wdata, mem_strb);
            end else if (wr && sel == 3'd1) begin
                mtime[63:32] <= merge(mtime[63:32], mem_wdata, mem_strb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr && sel == 3'd2) begin
                mtimecmp[31:0] <= merge(mtimecmp[31:0], mem_wdata, mem_strb);
            end
            if (wr && sel == 3'd3) begin
                mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, mem_strb);
            end
            if (wr && sel == 3'd4 && mem_strb[0]) begin
                ctrl_en   <= mem_wdata[0];
                ctrl_mask <= mem_wdata[1];
            end
            timer_irq <= !ctrl_mask && (mtime >= mtimecmp);
        end
    end

    // Response slot: reads sample the pre-write register value in the acceptance cycle.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= 32'd0;
        end else if (accept) begin
            mem_recv  <= 1'b1;
            mem_error <= sel_err;
            mem_rdata <= (mem_wen || sel_err) ? 32'd0 : rd_val;
        end else if (mem_recv && mem_ack) begin
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_scarv_soc_mtime.sv
// Directed bench for scarv_soc_mtime (PRESCALE=1, ADDR_LSB=2): bus timing, register map, irq.
module tb_scarv_soc_mtime;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_wen = 1'b0;
    logic [3:0]  mem_strb = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_recv;
    logic        mem_ack = 1'b0;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;

    scarv_soc_mtime dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_error (mem_error),
        .mem_rdata (mem_rdata),
        .timer_irq (timer_irq)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [2:0] sel);
        return 32'hA000_0000 | {27'd0, sel, 2'b00};
    endfunction

    // Called at a negedge; acceptance on the next posedge, ack on the one after.
    task automatic xfer(input logic wen, input logic [2:0] sel, input logic [3:0] strb,
                        input logic [31:0] wd, output logic [31:0] rdo, output logic ero);
        mem_req = 1'b1; mem_wen = wen; mem_addr = addr_of(sel);
        mem_strb = strb; mem_wdata = wd; mem_ack = 1'b0;
        #1 chk("gnt_idle", mem_gnt, 1);
        @(posedge g_clk); #1;
        mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'd0; mem_wdata = 32'd0;
        @(negedge g_clk);
        chk("recv_lat1", mem_recv, 1);
        rdo = mem_rdata; ero = mem_error;
        mem_ack = 1'b1;
        @(posedge g_clk); #1 mem_ack = 1'b0;
        @(negedge g_clk);
        chk("recv_drop", mem_recv, 0);
        chk("rdata_clr", mem_rdata, 0);
        chk("error_clr", mem_error, 0);
    endtask

    // Ends at the negedge where reset is released; the next posedge is the first active one.
    task automatic do_reset();
        mem_req = 1'b0; mem_ack = 1'b0; mem_wen = 1'b0;
        g_reset = 1'b1;
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge g_clk);
        do_reset();
        chk("rst_gnt", mem_gnt, 1);
        chk("rst_recv", mem_recv, 0);
        chk("rst_error", mem_error, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_irq", timer_irq, 0);

        // mtime counts from 0 after reset; read at P1 gives 0, read at P11 gives 10
        xfer(1'b0, 3'd0, 4'h0, 32'd0, rd, er);
        chk("mtime_first", rd, 32'd0);
        chk("mtime_first_err", er, 0);
        repeat (8) @(negedge g_clk);
        xfer(1'b0, 3'd0, 4'h0, 32'd0, rd, er);
        chk("mtime_after10", rd, 32'd10);
        xfer(1'b0, 3'd4, 4'h0, 32'd0, rd, er);
        chk("ctrl_reset", rd, 32'd1);
        xfer(1'b0, 3'd3, 4'h0, 32'd0, rd, er);
        chk("cmp_hi_reset", rd, 32'hFFFF_FFFF);

        // mtime writes: carry across words, or rejected in the default build
        do_reset();
`ifdef SCARV_SOC_MTIME_WRITE_EN
        xfer(1'b1, 3'd1, 4'hF, 32'd0, rd, er);
        chk("wr_hi_err", er, 0);
        xfer(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE, rd, er);
        chk("wr_lo_err", er, 0);
        @(negedge g_clk);
        xfer(1'b0, 3'd1, 4'h0, 32'd0, rd, er);
        chk("carry_hi", rd, 32'd1);
        xfer(1'b0, 3'd0, 4'h0, 32'd0, rd, er);
        chk("carry_lo", rd, 32'd2);
`else
        xfer(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE, rd, er);
        chk("wr_mtime_err", er, 1);
        xfer(1'b0, 3'd0, 4'h0, 32'd0, rd, er);
        chk("mtime_lo_kept", rd, 32'd2);
        xfer(1'b0, 3'd1, 4'h0, 32'd0, rd, er);
        chk("mtime_hi_kept", rd, 32'd0);
        chk("mtime_hi_err", er, 0);
`endif

        // Compare to 20: irq one cycle after mtime reaches 20, drops one cycle after mask
        do_reset();
        xfer(1'b1, 3'd3, 4'hF, 32'd0, rd, er);
        xfer(1'b1, 3'd2, 4'hF, 32'd20, rd, er);
        chk("cmp_wr_err", er, 0);
        repeat (16) @(negedge g_clk);
        chk("irq_before", timer_irq, 0);
        @(negedge g_clk);
        chk("irq_rise", timer_irq, 1);
        xfer(1'b1, 3'd4, 4'h1, 32'd3, rd, er);
        chk("irq_masked", timer_irq, 0);
        xfer(1'b0, 3'd4, 4'h0, 32'd0, rd, er);
        chk("ctrl_masked", rd, 32'd3);

        // Byte-lane write into mtimecmp low word
        do_reset();
        xfer(1'b1, 3'd2, 4'b0100, 32'h00AB_0000, rd, er);
        xfer(1'b0, 3'd2, 4'h0, 32'd0, rd, er);
        chk("byte_wr", rd, 32'hFFAB_FFFF);
        xfer(1'b1, 3'd3, 4'h0, 32'h1234_5678, rd, er);
        chk("strb0_err", er, 0);
        xfer(1'b0, 3'd3, 4'h0, 32'd0, rd, er);
        chk("strb0_noop", rd, 32'hFFFF_FFFF);

        // Unmapped select
        do_reset();
        xfer(1'b0, 3'd6, 4'h0, 32'd0, rd, er);
        chk("sel6_rd_data", rd, 32'd0);
        chk("sel6_rd_err", er, 1);
        xfer(1'b1, 3'd6, 4'hF, 32'h0000_0002, rd, er);
        chk("sel6_wr_err", er, 1);
        xfer(1'b0, 3'd4, 4'h0, 32'd0, rd, er);
        chk("sel6_ctrl_kept", rd, 32'd1);
        xfer(1'b0, 3'd2, 4'h0, 32'd0, rd, er);
        chk("sel6_cmp_kept", rd, 32'hFFFF_FFFF);

        // Disable: mtime holds at 1 after ctrl write at P1
        do_reset();
        xfer(1'b1, 3'd4, 4'h1, 32'd0, rd, er);
        xfer(1'b0, 3'd0, 4'h0, 32'd0, rd, er);
        chk("hold_mtime", rd, 32'd1);

        // Backpressure: response held 5 cycles, second request waits, then no bubble
        do_reset();
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = addr_of(3'd4); mem_ack = 1'b0;
        @(posedge g_clk); #1 mem_addr = addr_of(3'd2);
        @(negedge g_clk);
        chk("bp_first_data", mem_rdata, 32'd1);
        chk("bp_first_err", mem_error, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_gnt_low", mem_gnt, 0);
            chk("bp_recv_held", mem_recv, 1);
            chk("bp_rdata_stable", mem_rdata, 32'd1);
            @(negedge g_clk);
        end
        mem_ack = 1'b1;
        #1 chk("bp_gnt_on_ack", mem_gnt, 1);
        @(posedge g_clk); #1 begin mem_req = 1'b0; mem_ack = 1'b0; end
        @(negedge g_clk);
        chk("bp_second_recv", mem_recv, 1);
        chk("bp_second_data", mem_rdata, 32'hFFFF_FFFF);
        mem_ack = 1'b1;
        @(posedge g_clk); #1 mem_ack = 1'b0;
        @(negedge g_clk);
        chk("bp_done", mem_recv, 0);

        // Reset mid-transaction discards the pending response
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = addr_of(3'd0);
        @(posedge g_clk); #1 mem_req = 1'b0;
        @(negedge g_clk);
        chk("mid_recv", mem_recv, 1);
        g_reset = 1'b1;
        @(negedge g_clk);
        chk("mid_rst_recv", mem_recv, 0);
        chk("mid_rst_gnt", mem_gnt, 1);
        g_reset = 1'b0;
        @(negedge g_clk);
        chk("mid_no_late", mem_recv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
